// File: rtl/pe_sched.sv
// pe_sched: sequencer for one PE. On start it loads INST_NUM instructions, then
// DWORDS operand words, runs the program for max(iter_num,1) iterations, and
// captures the first dout_pe seen in the last iteration or the drain window.
// Optional macro PE_SCHED_WDOG_EN adds a load watchdog that sets err[1] and aborts.
// Ports:
//   clk, rst (sync, active-low)      : clock / reset
//   start, iter_num                  : job request and iteration count
//   busy, done, err[1:0]             : job status (err: [0] load gap, [1] watchdog)
//   s_inst_v/s_inst/s_inst_rdy       : instruction stream in
//   s_data_v/s_data/s_data_rdy       : operand stream in
//   inst_in_v/inst_in, din_pe_v/din_pe, alpha_v : to pe
//   dout_pe_v/dout_pe                : from pe
//   res_v, res                       : captured result
module pe_sched #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned INST_W    = 32,
    parameter int unsigned INST_NUM  = 16,
    parameter int unsigned DWORDS    = 16,
    parameter int unsigned ITER_W    = 8,
    parameter int unsigned DRAIN_CYC = 14,
    parameter int unsigned WDOG_CYC  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ITER_W-1:0] iter_num,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err,
    input  logic              s_inst_v,
    input  logic [INST_W-1:0] s_inst,
    output logic              s_inst_rdy,
    input  logic              s_data_v,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_data_rdy,
    output logic              inst_in_v,
    output logic [INST_W-1:0] inst_in,
    output logic              din_pe_v,
    output logic [DATA_W-1:0] din_pe,
    output logic              alpha_v,
    input  logic              dout_pe_v,
    input  logic [DATA_W-1:0] dout_pe,
    output logic              res_v,
    output logic [DATA_W-1:0] res
);

    localparam int unsigned MAX_ID  = (INST_NUM > DWORDS) ? INST_NUM : DWORDS;
    localparam int unsigned CNT_MAX = (MAX_ID > DRAIN_CYC) ? MAX_ID : DRAIN_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, LD_INST, LD_DATA, RUN, DRAIN} state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [ITER_W-1:0]   it, it_nxt, iters, iters_nxt;
    logic [1:0]          err_nxt;
    logic                got, got_nxt;
    logic [DATA_W-1:0]   res_nxt, din_nxt;
    logic [INST_W-1:0]   inst_nxt;
    logic                res_v_nxt, done_nxt, inst_v_nxt, din_v_nxt, alpha_nxt;
    logic                inst_beat, data_beat, last_iter;

    assign inst_beat = s_inst_v & s_inst_rdy;
    assign data_beat = s_data_v & s_data_rdy;
    assign last_iter = (it == iters - ITER_W'(1));

`ifdef PE_SCHED_WDOG_EN
    localparam int unsigned WD_W = $clog2(WDOG_CYC + 1);
    logic [WD_W-1:0] wd, wd_nxt;
`else
    logic unused_wdog;
    assign unused_wdog = (WDOG_CYC == 0);
`endif

    // Next-state, counters and registered-output lookahead
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        it_nxt     = it;
        iters_nxt  = iters;
        err_nxt    = err;
        got_nxt    = got;
        res_nxt    = res;
        res_v_nxt  = 1'b0;
        done_nxt   = 1'b0;
        inst_v_nxt = 1'b0;
        inst_nxt   = inst_in;
        din_v_nxt  = 1'b0;
        din_nxt    = din_pe;
`ifdef PE_SCHED_WDOG_EN
        wd_nxt     = wd;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    iters_nxt = (iter_num == '0) ? ITER_W'(1) : iter_num;
                    err_nxt   = 2'b00;
                    got_nxt   = 1'b0;
                    cnt_nxt   = '0;
                    it_nxt    = '0;
                    state_nxt = LD_INST;
`ifdef PE_SCHED_WDOG_EN
                    wd_nxt    = '0;
`endif
                end
            end
            LD_INST: begin
                if (inst_beat) begin
                    inst_v_nxt = 1'b1;
                    inst_nxt   = s_inst;
                    if (cnt == CNT_W'(INST_NUM - 1)) begin
                        cnt_nxt   = '0;
                        state_nxt = LD_DATA;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            LD_DATA: begin
                if (data_beat) begin
                    din_v_nxt = 1'b1;
                    din_nxt   = s_data;
                    if (cnt == CNT_W'(DWORDS - 1)) begin
                        cnt_nxt   = '0;
                        state_nxt = RUN;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end else if (cnt != '0) begin
                    // PE restarts its write count on a gap; flag it, keep loading
                    err_nxt[0] = 1'b1;
                end
            end
            RUN: begin
                if (cnt == CNT_W'(INST_NUM - 1)) begin
                    cnt_nxt = '0;
                    if (last_iter) begin
                        state_nxt = DRAIN;
                    end else begin
                        it_nxt = it + ITER_W'(1);
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (cnt == CNT_W'(DRAIN_CYC - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        // First result of the final iteration or drain window wins
        if (((state == RUN && last_iter) || state == DRAIN) && dout_pe_v && !got) begin
            res_nxt   = dout_pe;
            res_v_nxt = 1'b1;
            got_nxt   = 1'b1;
        end

`ifdef PE_SCHED_WDOG_EN
        // Cycles since last accepted beat; abort the job when the limit is hit
        if (state == LD_INST || state == LD_DATA) begin
            if (inst_beat || data_beat) begin
                wd_nxt = '0;
            end else if (wd == WD_W'(WDOG_CYC - 1)) begin
                wd_nxt     = '0;
                cnt_nxt    = '0;
                err_nxt[1] = 1'b1;
                done_nxt   = 1'b1;
                state_nxt  = IDLE;
            end else begin
                wd_nxt = wd + WD_W'(1);
            end
        end
`endif

        // done is shown during the final drain cycle, so a start then is not accepted
        done_nxt  = done_nxt |
                    ((state_nxt == DRAIN) && (cnt_nxt == CNT_W'(DRAIN_CYC - 1)));
        alpha_nxt = ((state_nxt == RUN) && (it_nxt == iters_nxt - ITER_W'(1))) ||
                    (state_nxt == DRAIN);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counters and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt        <= '0;
            it         <= '0;
            iters      <= '0;
            got        <= 1'b0;
            err        <= 2'b00;
            busy       <= 1'b0;
            done       <= 1'b0;
            s_inst_rdy <= 1'b0;
            s_data_rdy <= 1'b0;
            inst_in_v  <= 1'b0;
            inst_in    <= '0;
            din_pe_v   <= 1'b0;
            din_pe     <= '0;
            alpha_v    <= 1'b0;
            res_v      <= 1'b0;
            res        <= '0;
`ifdef PE_SCHED_WDOG_EN
            wd         <= '0;
`endif
        end else begin
            cnt        <= cnt_nxt;
            it         <= it_nxt;
            iters      <= iters_nxt;
            got        <= got_nxt;
            err        <= err_nxt;
            busy       <= (state_nxt != IDLE);
            done       <= done_nxt;
            s_inst_rdy <= (state_nxt == LD_INST);
            s_data_rdy <= (state_nxt == LD_DATA);
            inst_in_v  <= inst_v_nxt;
            inst_in    <= inst_nxt;
            din_pe_v   <= din_v_nxt;
            din_pe     <= din_nxt;
            alpha_v    <= alpha_nxt;
            res_v      <= res_v_nxt;
            res        <= res_nxt;
`ifdef PE_SCHED_WDOG_EN
            wd         <= wd_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_pe_sched.sv
// Directed bench for pe_sched: reset, full jobs, result capture, load gap,
// iteration count of zero, ignored start, and the load watchdog / stall case.
module tb_pe_sched;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned INST_W    = 32;
    localparam int unsigned ITER_W    = 8;
    localparam logic [31:0] INST_BASE = 32'hA000_0000;
    localparam logic [31:0] DATA_BASE = 32'h5000_0100;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ITER_W-1:0] iter_num;
    logic              busy, done;
    logic [1:0]        err;
    logic              s_inst_v, s_inst_rdy, s_data_v, s_data_rdy;
    logic [INST_W-1:0] s_inst, inst_in;
    logic [DATA_W-1:0] s_data, din_pe, dout_pe, res;
    logic              inst_in_v, din_pe_v, alpha_v, dout_pe_v, res_v;

    pe_sched #(.WDOG_CYC(8)) dut (
        .clk(clk), .rst(rst), .start(start), .iter_num(iter_num),
        .busy(busy), .done(done), .err(err),
        .s_inst_v(s_inst_v), .s_inst(s_inst), .s_inst_rdy(s_inst_rdy),
        .s_data_v(s_data_v), .s_data(s_data), .s_data_rdy(s_data_rdy),
        .inst_in_v(inst_in_v), .inst_in(inst_in),
        .din_pe_v(din_pe_v), .din_pe(din_pe), .alpha_v(alpha_v),
        .dout_pe_v(dout_pe_v), .dout_pe(dout_pe),
        .res_v(res_v), .res(res)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc;

    // Per-job observations
    int          j_done, j_ninst, j_ndin, j_afirst, j_alast, j_acnt, j_rcnt, j_rcyc;
    logic [31:0] j_ifirst, j_ilast, j_dfirst, j_dlast;
    logic [1:0]  j_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One job; cycle 1 is the start cycle. dout_a/dout_b pulse dout_pe_v on
    // those cycles (dout_a carries 32'h1111_1111), start is re-asserted at
    // st_cyc and on the done cycle.
    task automatic run_job(input logic [7:0] iters, input bit gap, input int dout_a,
                           input int dout_b, input logic [31:0] dval, input int st_cyc);
        int gap_left, inst_sent, data_sent;
        gap_left = 2; inst_sent = 0; data_sent = 0;
        j_done = 0; j_ninst = 0; j_ndin = 0; j_afirst = 0; j_alast = 0; j_acnt = 0;
        j_rcnt = 0; j_rcyc = 0; j_err = 2'b11;
        cyc = 1; start = 1'b1; iter_num = iters; s_inst_v = 1'b1; s_data_v = 1'b1;
        s_inst = INST_BASE; s_data = DATA_BASE;
        step();
        start = 1'b0;
        for (int k = 0; k < 400 && j_done == 0; k++) begin
            if (inst_in_v) begin
                if (j_ninst == 0) j_ifirst = inst_in;
                j_ilast = inst_in; j_ninst++;
            end
            if (din_pe_v) begin
                if (j_ndin == 0) j_dfirst = din_pe;
                j_dlast = din_pe; j_ndin++;
            end
            if (alpha_v) begin
                if (j_afirst == 0) j_afirst = cyc;
                j_alast = cyc; j_acnt++;
            end
            if (res_v) begin
                j_rcnt++; j_rcyc = cyc;
            end
            if (done) begin
                j_done = cyc; j_err = err;
            end
            s_inst   = INST_BASE + 32'(inst_sent);
            s_data   = DATA_BASE + 32'(data_sent);
            s_data_v = 1'b1;
            if (gap && data_sent == 5 && s_data_rdy && gap_left > 0) begin
                s_data_v = 1'b0; gap_left--;
            end
            dout_pe_v = (cyc == dout_a) || (cyc == dout_b);
            dout_pe   = (cyc == dout_a) ? 32'h1111_1111 : dval;
            start     = (cyc == st_cyc) || done;
            if (s_inst_v && s_inst_rdy) inst_sent++;
            if (s_data_v && s_data_rdy) data_sent++;
            step();
        end
        start = 1'b0; dout_pe_v = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; iter_num = '0; s_inst_v = 1'b0; s_inst = '0;
        s_data_v = 1'b0; s_data = '0; dout_pe_v = 1'b0; dout_pe = '0; cyc = 0;
        repeat (3) step();
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_done",  64'(done), 64'd0);
        check("rst_err",   64'(err), 64'd0);
        check("rst_alpha", 64'(alpha_v), 64'd0);
        check("rst_res",   64'({res_v, res}), 64'd0);
        check("rst_rdy",   64'({s_inst_rdy, s_data_rdy}), 64'd0);
        rst = 1'b1;
        step();

        // Reset in the middle of the operand load
        cyc = 1; start = 1'b1; iter_num = 8'd2; s_inst_v = 1'b1; s_data_v = 1'b1;
        step();
        start = 1'b0;
        repeat (20) step();
        check("mid_ld_data_v", 64'({s_data_rdy, din_pe_v}), 64'b11);
        rst = 1'b0;
        step();
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_din",  64'(din_pe_v), 64'd0);
        check("rst_mid_rdy",  64'(s_data_rdy), 64'd0);
        step(); step();
        rst = 1'b1;
        step();
        check("rst_mid_idle", 64'({busy, err}), 64'd0);

        // 3 iterations; early dout in iteration 0 ignored, DEAD_BEEF in drain captured
        run_job(8'd3, 1'b0, 40, 85, 32'hDEAD_BEEF, 0);
        check("j3_done_cyc", 64'(j_done), 64'd95);
        check("j3_ninst",    64'(j_ninst), 64'd16);
        check("j3_inst_1st", 64'(j_ifirst), 64'(INST_BASE));
        check("j3_inst_last",64'(j_ilast), 64'(INST_BASE + 32'd15));
        check("j3_ndin",     64'(j_ndin), 64'd16);
        check("j3_din_1st",  64'(j_dfirst), 64'(DATA_BASE));
        check("j3_din_last", 64'(j_dlast), 64'(DATA_BASE + 32'd15));
        check("j3_alpha_1st",64'(j_afirst), 64'd66);
        check("j3_alpha_end",64'(j_alast), 64'd95);
        check("j3_alpha_cnt",64'(j_acnt), 64'd30);
        check("j3_res_cnt",  64'(j_rcnt), 64'd1);
        check("j3_res_cyc",  64'(j_rcyc), 64'd86);
        check("j3_res",      64'(res), 64'hDEAD_BEEF);
        check("j3_err",      64'(j_err), 64'd0);
        check("j3_post",     64'({busy, done, alpha_v}), 64'd0);
        step();
        check("j3_post_idle",64'(busy), 64'd0);

        // Two-cycle operand gap after beat 5
        run_job(8'd2, 1'b1, 0, 0, 32'h0, 0);
        check("gap_done_cyc", 64'(j_done), 64'd81);
        check("gap_err",      64'(j_err), 64'b01);
        check("gap_ndin",     64'(j_ndin), 64'd16);
        check("gap_din_last", 64'(j_dlast), 64'(DATA_BASE + 32'd15));
        check("gap_res_cnt",  64'(j_rcnt), 64'd0);
        check("gap_res_held", 64'(res), 64'hDEAD_BEEF);

        // iter_num=0 runs one iteration; start during RUN ignored; capture in RUN
        run_job(8'd0, 1'b0, 0, 45, 32'h0BAD_F00D, 40);
        check("it0_done_cyc",  64'(j_done), 64'd63);
        check("it0_alpha_1st", 64'(j_afirst), 64'd34);
        check("it0_alpha_end", 64'(j_alast), 64'd63);
        check("it0_alpha_cnt", 64'(j_acnt), 64'd30);
        check("it0_err_clr",   64'(j_err), 64'd0);
        check("it0_res_cyc",   64'(j_rcyc), 64'd46);
        check("it0_res",       64'(res), 64'h0BAD_F00D);
        check("it0_post",      64'({busy, done}), 64'd0);

        // Instruction stream stops after 4 beats
        cyc = 1; start = 1'b1; iter_num = 8'd1; s_inst_v = 1'b1;
        step();
        start = 1'b0;
        begin
            int sent, dcyc;
            sent = 0; dcyc = 0;
            for (int k = 0; k < 40 && dcyc == 0; k++) begin
                if (done) dcyc = cyc;
                s_inst_v = (sent < 4);
                if (s_inst_v && s_inst_rdy) sent++;
                if (dcyc == 0) step();
            end
`ifdef PE_SCHED_WDOG_EN
            check("wd_done_cyc", 64'(dcyc), 64'd14);
            check("wd_err",      64'(err), 64'b10);
            check("wd_busy",     64'({busy, s_inst_rdy}), 64'd0);
            step();
            check("wd_post",     64'({done, inst_in_v}), 64'd0);
`else
            check("stall_no_done", 64'(dcyc), 64'd0);
            check("stall_busy",    64'({busy, s_inst_rdy}), 64'b11);
            check("stall_err",     64'(err), 64'd0);
            rst = 1'b0;
            step();
            rst = 1'b1;
            step();
            check("stall_rst", 64'(busy), 64'd0);
`endif
        end

        // Clean job after the abort / reset
        run_job(8'd1, 1'b0, 0, 0, 32'h0, 0);
        check("last_done_cyc", 64'(j_done), 64'd63);
        check("last_err",      64'(j_err), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
